memctrl_arbiter: RTL

- Round-robin arbiter and sequencer that shares one MEMCTRL port among NREQ independent requesters (DMA, CPU bridge, test port, etc.).
- Accepts single-byte read/write requests over a valid/ready handshake and drives the MEMCTRL pins: ADDR, CE, CSB, WEB, OEB, IDATA.
- Captures MEMCTRL ODATA for reads and returns it to the owning requester.
- Sits directly above MEMCTRL; it is the only master of the MEMCTRL pins.

---
 rtl/memctrl_arb_pkg.sv | 25 ++
 rtl/memctrl_rr_pick.sv | 33 +++
 rtl/memctrl_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/memctrl_arb_pkg.sv
// Shared types and constants for the MEMCTRL round-robin arbiter.
package memctrl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // MEMCTRL pin levels while no access is in progress
    localparam logic IDLE_CE  = 1'b0;
    localparam logic IDLE_CSB = 1'b1;
    localparam logic IDLE_WEB = 1'b1;
    localparam logic IDLE_OEB = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/memctrl_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
module memctrl_rr_pick
    import memctrl_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_c,
    output logic [PW-1:0]   idx_c,
    output logic            any_c
);

    int unsigned pos;

    // Scan from the far end so the candidate nearest the pointer wins last
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        pos   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            pos = (32'(ptr_i) + 32'(k)) % NREQ;
            if (valid_i[PW'(pos)]) begin
                idx_c = PW'(pos);
                any_c = 1'b1;
            end
        end
        if (any_c) gnt_c[idx_c] = 1'b1;
    end

endmodule

// File: rtl/memctrl_arbiter.sv
// Round-robin arbiter/sequencer giving NREQ requesters single-byte access
// to the one MEMCTRL port; all pin and response outputs are registered.
module memctrl_arbiter
    import memctrl_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          REQ_VALID,
    input  logic [NREQ-1:0]          REQ_WE,
    input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]          REQ_READY,
    output logic [NREQ-1:0]          RSP_VALID,
    output logic [DATA_W-1:0]        RSP_DATA,
    output logic [ADDR_W-1:0]        M_ADDR,
    output logic                     M_CE,
    output logic                     M_CSB,
    output logic                     M_WEB,
    output logic                     M_OEB,
    output logic [DATA_W-1:0]        M_IDATA,
    input  logic [DATA_W-1:0]        M_ODATA,
    output logic                     BUSY
);

    localparam int unsigned PW = clog2(NREQ);
    localparam int unsigned CW = clog2(RD_LAT + 1);

    arb_state_e        state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [PW-1:0]     owner_q;
    logic              we_q;
    logic [CW-1:0]     cnt_q;

    logic [NREQ-1:0]   pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    memctrl_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid_i (REQ_VALID),
        .ptr_i   (ptr_q),
        .gnt_c   (pick_gnt),
        .idx_c   (pick_idx),
        .any_c   (pick_any)
    );

    assign sel_addr  = REQ_ADDR[32'(pick_idx) * ADDR_W +: ADDR_W];
    assign sel_wdata = REQ_WDATA[32'(pick_idx) * DATA_W +: DATA_W];
    assign sel_we    = REQ_WE[pick_idx];
    assign ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);

    // Grant is only offered from IDLE and never while reset is asserted
    assign REQ_READY = (!RST && state_q == ST_IDLE) ? pick_gnt : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            M_CE      <= IDLE_CE;
            M_CSB     <= IDLE_CSB;
            M_WEB     <= IDLE_WEB;
            M_OEB     <= IDLE_OEB;
            M_ADDR    <= '0;
            M_IDATA   <= '0;
            RSP_VALID <= '0;
            RSP_DATA  <= '0;
            BUSY      <= 1'b0;
        end else begin
            RSP_VALID <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        we_q    <= sel_we;
                        ptr_q   <= ptr_d;
                        state_q <= ST_ISSUE;
                        BUSY    <= 1'b1;
                        M_CE    <= 1'b1;
                        M_CSB   <= 1'b0;
                        M_ADDR  <= sel_addr;
                        M_WEB   <= ~sel_we;
                        M_OEB   <= sel_we;
                        if (sel_we) M_IDATA <= sel_wdata;
                    end
                end
                ST_ISSUE: begin
                    if (we_q) begin
                        state_q <= ST_IDLE;
                        BUSY    <= 1'b0;
                        M_CE    <= IDLE_CE;
                        M_CSB   <= IDLE_CSB;
                        M_WEB   <= IDLE_WEB;
                        M_OEB   <= IDLE_OEB;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CW'(RD_LAT);
                    end
                end
                ST_WAIT: begin
                    // Read pins stay asserted until the data-capture edge
                    if (cnt_q == CW'(1)) begin
                        RSP_DATA           <= M_ODATA;
                        RSP_VALID[owner_q] <= 1'b1;
                        state_q            <= ST_IDLE;
                        BUSY               <= 1'b0;
                        M_CE               <= IDLE_CE;
                        M_CSB              <= IDLE_CSB;
                        M_WEB              <= IDLE_WEB;
                        M_OEB              <= IDLE_OEB;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    BUSY    <= 1'b0;
                    M_CE    <= IDLE_CE;
                    M_CSB   <= IDLE_CSB;
                    M_WEB   <= IDLE_WEB;
                    M_OEB   <= IDLE_OEB;
                end
            endcase
        end
    end

endmodule
